// File: rtl/hydra_pkt_gen_if.sv
// Write-side bundle between the packet generator (master) and the hydra switch (slave).
interface hydra_pkt_gen_if #(
    parameter int PORT_NUM   = 16,
    parameter int DATA_WIDTH = 16
);
    logic [PORT_NUM-1:0]                 wr_sop;
    logic [PORT_NUM-1:0]                 wr_eop;
    logic [PORT_NUM-1:0]                 wr_vld;
    logic [PORT_NUM-1:0][DATA_WIDTH-1:0] wr_data;
    logic [PORT_NUM-1:0]                 pause;

    modport master (output wr_sop, wr_eop, wr_vld, wr_data, input pause);
    modport slave  (input wr_sop, wr_eop, wr_vld, wr_data, output pause);
endinterface

// File: rtl/hydra_pkt_gen.sv
// Multi-port packet generator: per-port configurable header, payload pattern, count and gap.
module hydra_pkt_gen #(
    parameter int PORT_NUM   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 9,
    parameter int PRI_WIDTH  = 3,
    parameter int DEST_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(PORT_NUM)-1:0]  cfg_port,
    input  logic [DEST_WIDTH-1:0]        cfg_dest,
    input  logic [PRI_WIDTH-1:0]         cfg_prio,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic [CNT_WIDTH-1:0]         cfg_pkts,
    input  logic [CNT_WIDTH-1:0]         cfg_gap,
    output logic                         cfg_err,
    input  logic [PORT_NUM-1:0]          start,
    input  logic [PORT_NUM-1:0]          stop,
    output logic [PORT_NUM-1:0]          busy,
    output logic [PORT_NUM-1:0]          done,
    hydra_pkt_gen_if.master              wr
);
    localparam int PW = $clog2(PORT_NUM);
    localparam int HW = DATA_WIDTH / 2;

    typedef enum logic [2:0] {IDLE, SOP, HDR, PAY, EOP, GAP, DONE} state_e;

    state_e                state_q    [PORT_NUM];
    state_e                state_d    [PORT_NUM];
    logic [LEN_WIDTH-1:0]  beat_q     [PORT_NUM];
    logic [LEN_WIDTH-1:0]  beat_d     [PORT_NUM];
    logic [CNT_WIDTH-1:0]  sent_q     [PORT_NUM];
    logic [CNT_WIDTH-1:0]  sent_d     [PORT_NUM];
    logic [CNT_WIDTH-1:0]  gap_q      [PORT_NUM];
    logic [CNT_WIDTH-1:0]  gap_d      [PORT_NUM];
    logic [HW-1:0]         seq_q      [PORT_NUM];
    logic [HW-1:0]         seq_d      [PORT_NUM];
    logic [DEST_WIDTH-1:0] cfg_dest_q [PORT_NUM];
    logic [DEST_WIDTH-1:0] cfg_dest_d [PORT_NUM];
    logic [PRI_WIDTH-1:0]  cfg_prio_q [PORT_NUM];
    logic [PRI_WIDTH-1:0]  cfg_prio_d [PORT_NUM];
    logic [LEN_WIDTH-1:0]  cfg_len_q  [PORT_NUM];
    logic [LEN_WIDTH-1:0]  cfg_len_d  [PORT_NUM];
    logic [CNT_WIDTH-1:0]  cfg_pkts_q [PORT_NUM];
    logic [CNT_WIDTH-1:0]  cfg_pkts_d [PORT_NUM];
    logic [CNT_WIDTH-1:0]  cfg_gap_q  [PORT_NUM];
    logic [CNT_WIDTH-1:0]  cfg_gap_d  [PORT_NUM];

    logic [PORT_NUM-1:0]   stop_q, stop_d, stop_any, cfg_ok;
    logic [PORT_NUM-1:0]   sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
    logic [PORT_NUM-1:0]   busy_q, busy_d, done_q, done_d;
    logic [PORT_NUM-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic                  cfg_err_q, cfg_err_d;

    function automatic logic is_idle(input state_e s);
        return (s == IDLE) || (s == DONE);
    endfunction

    function automatic state_e decide(input logic [CNT_WIDTH-1:0] sent,
                                      input logic [CNT_WIDTH-1:0] pkts,
                                      input logic stp);
        return (stp || ((pkts != '0) && (sent == pkts))) ? DONE : SOP;
    endfunction

    assign stop_any = stop_q | stop;

    always_comb begin
        cfg_ok = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            cfg_ok[p] = cfg_we && (cfg_port == PW'(p)) && is_idle(state_q[p]) && (cfg_len != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                state_q[p]    <= IDLE;
                beat_q[p]     <= '0;
                sent_q[p]     <= '0;
                gap_q[p]      <= '0;
                seq_q[p]      <= '0;
                cfg_dest_q[p] <= DEST_WIDTH'(p);
                cfg_prio_q[p] <= '0;
                cfg_len_q[p]  <= LEN_WIDTH'(1);
                cfg_pkts_q[p] <= CNT_WIDTH'(1);
                cfg_gap_q[p]  <= '0;
            end
            stop_q    <= '0;
            sop_q     <= '0;
            eop_q     <= '0;
            vld_q     <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            data_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            sent_q     <= sent_d;
            gap_q      <= gap_d;
            seq_q      <= seq_d;
            cfg_dest_q <= cfg_dest_d;
            cfg_prio_q <= cfg_prio_d;
            cfg_len_q  <= cfg_len_d;
            cfg_pkts_q <= cfg_pkts_d;
            cfg_gap_q  <= cfg_gap_d;
            stop_q     <= stop_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_q     <= data_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // state_q names the next item to emit; pause holds it so nothing is lost or repeated
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        sent_d     = sent_q;
        gap_d      = gap_q;
        seq_d      = seq_q;
        stop_d     = stop_q;
        cfg_dest_d = cfg_dest_q;
        cfg_prio_d = cfg_prio_q;
        cfg_len_d  = cfg_len_q;
        cfg_pkts_d = cfg_pkts_q;
        cfg_gap_d  = cfg_gap_q;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (cfg_ok[p]) begin
                cfg_dest_d[p] = cfg_dest;
                cfg_prio_d[p] = cfg_prio;
                cfg_len_d[p]  = cfg_len;
                cfg_pkts_d[p] = cfg_pkts;
                cfg_gap_d[p]  = cfg_gap;
            end
            if (!is_idle(state_q[p]) && stop[p]) stop_d[p] = 1'b1;
            unique case (state_q[p])
                IDLE, DONE: if (start[p]) begin
                    state_d[p] = SOP;
                    sent_d[p]  = '0;
                    stop_d[p]  = 1'b0;
                end
                SOP: if (stop_any[p]) state_d[p] = DONE;
                     else if (!wr.pause[p]) state_d[p] = HDR;
                HDR: if (!wr.pause[p]) begin
                    state_d[p] = PAY;
                    beat_d[p]  = '0;
                end
                PAY: if (!wr.pause[p]) begin
                    if (beat_q[p] == cfg_len_q[p] - LEN_WIDTH'(1)) state_d[p] = EOP;
                    else beat_d[p] = beat_q[p] + LEN_WIDTH'(1);
                end
                EOP: begin
                    seq_d[p]  = seq_q[p] + HW'(1);
                    sent_d[p] = sent_q[p] + CNT_WIDTH'(1);
                    if (cfg_gap_q[p] != '0) begin
                        state_d[p] = GAP;
                        gap_d[p]   = cfg_gap_q[p];
                    end else begin
                        state_d[p] = decide(sent_q[p] + CNT_WIDTH'(1), cfg_pkts_q[p], stop_any[p]);
                    end
                end
                GAP: if (gap_q[p] <= CNT_WIDTH'(1)) state_d[p] = decide(sent_q[p], cfg_pkts_q[p], stop_any[p]);
                     else gap_d[p] = gap_q[p] - CNT_WIDTH'(1);
                default: state_d[p] = IDLE;
            endcase
        end
    end

    always_comb begin
        sop_d     = '0;
        eop_d     = '0;
        vld_d     = '0;
        busy_d    = '0;
        done_d    = '0;
        data_d    = '0;
        cfg_err_d = cfg_we && (cfg_ok == '0);
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            busy_d[p] = !is_idle(state_d[p]);
            done_d[p] = (state_q[p] == DONE) && !start[p];
            case (state_q[p])
                SOP: sop_d[p] = !wr.pause[p] && !stop_any[p];
                HDR: if (!wr.pause[p]) begin
                    vld_d[p]  = 1'b1;
                    data_d[p] = DATA_WIDTH'({cfg_len_q[p], cfg_prio_q[p], cfg_dest_q[p]});
                end
                PAY: if (!wr.pause[p]) begin
                    vld_d[p]  = 1'b1;
                    data_d[p] = DATA_WIDTH'({seq_q[p], HW'(beat_q[p])});
                end
                EOP: eop_d[p] = 1'b1;
                default: ;
            endcase
        end
    end

    assign wr.wr_sop  = sop_q;
    assign wr.wr_eop  = eop_q;
    assign wr.wr_vld  = vld_q;
    assign wr.wr_data = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_hydra_pkt_gen.sv
// Directed bench for hydra_pkt_gen with a per-port scoreboard of expected sop/beat/eop items.
module tb_hydra_pkt_gen;
    localparam int NP = 16, DW = 16, LW = 9, PRW = 3, DSW = 4, CW = 16, PB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [PB-1:0]  cfg_port = '0;
    logic [DSW-1:0] cfg_dest = '0;
    logic [PRW-1:0] cfg_prio = '0;
    logic [LW-1:0]  cfg_len = '0;
    logic [CW-1:0]  cfg_pkts = '0;
    logic [CW-1:0]  cfg_gap = '0;
    logic           cfg_err;
    logic [NP-1:0]  start = '0;
    logic [NP-1:0]  stop = '0;
    logic [NP-1:0]  busy, done;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q [NP][$];
    int sop_cnt [NP];
    int eop_cnt [NP];
    int cur_beats [NP];
    int pkt_beats [NP];

    hydra_pkt_gen_if #(.PORT_NUM(NP), .DATA_WIDTH(DW)) wr_if ();

    hydra_pkt_gen #(
        .PORT_NUM(NP), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .PRI_WIDTH(PRW), .DEST_WIDTH(DSW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_dest(cfg_dest), .cfg_prio(cfg_prio),
        .cfg_len(cfg_len), .cfg_pkts(cfg_pkts), .cfg_gap(cfg_gap), .cfg_err(cfg_err),
        .start(start), .stop(stop), .busy(busy), .done(done),
        .wr(wr_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic s, input logic v, input logic e, input logic [DW-1:0] d);
        return {13'd0, s, v, e, d};
    endfunction

    task automatic push_pkt(input int p, input int len, input int prio, input int dest, input int seq);
        logic [DW-1:0] hdr;
        hdr = {LW'(len), PRW'(prio), DSW'(dest)};
        exp_q[p].push_back(enc(1'b1, 1'b0, 1'b0, '0));
        exp_q[p].push_back(enc(1'b0, 1'b1, 1'b0, hdr));
        for (int k = 0; k < len; k++)
            exp_q[p].push_back(enc(1'b0, 1'b1, 1'b0, {8'(seq), 8'(k)}));
        exp_q[p].push_back(enc(1'b0, 1'b0, 1'b1, '0));
    endtask

    task automatic cfg_write(input int p, input int dest, input int prio, input int len,
                             input int pkts, input int gap);
        cfg_we = 1'b1; cfg_port = PB'(p); cfg_dest = DSW'(dest); cfg_prio = PRW'(prio);
        cfg_len = LW'(len); cfg_pkts = CW'(pkts); cfg_gap = CW'(gap);
        tick();
        cfg_we = 1'b0;
    endtask

    function automatic logic flag(input int p, input int which);
        case (which)
            0:       return wr_if.wr_sop[p];
            1:       return wr_if.wr_eop[p];
            default: return done[p];
        endcase
    endfunction

    task automatic wait_flag(input string tag, input int p, input int which, input int budget);
        int n = 0;
        while (flag(p, which) == 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(flag(p, which)), 32'd1);
    endtask

    function automatic int q_total();
        int s = 0;
        for (int p = 0; p < NP; p++) s += exp_q[p].size();
        return s;
    endfunction

    always @(negedge clk) begin
        logic [31:0] obs;
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                obs = enc(wr_if.wr_sop[p], wr_if.wr_vld[p], wr_if.wr_eop[p], wr_if.wr_data[p]);
                if (wr_if.wr_sop[p]) begin sop_cnt[p]++; cur_beats[p] = 0; end
                if (wr_if.wr_vld[p]) cur_beats[p]++;
                if (wr_if.wr_eop[p]) begin eop_cnt[p]++; pkt_beats[p] = cur_beats[p]; end
                if (wr_if.wr_sop[p] || wr_if.wr_vld[p] || wr_if.wr_eop[p]) begin
                    if (exp_q[p].size() == 0) check($sformatf("sb_extra_p%0d", p), obs, 32'hFFFF_FFFF);
                    else check($sformatf("sb_p%0d", p), obs, exp_q[p].pop_front());
                end
            end
        end
    end

    initial begin
        int idle;
        int n;
        wr_if.pause = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_sop", 32'(wr_if.wr_sop), 32'd0);
        check("rst_vld", 32'(wr_if.wr_vld), 32'd0);
        check("rst_eop", 32'(wr_if.wr_eop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // port 0, default config
        push_pkt(0, 1, 0, 0, 0);
        start[0] = 1'b1; tick(); start = '0;
        tick(); check("p0_sop", 32'(wr_if.wr_sop[0]), 32'd1);
                check("p0_sop_vld", 32'(wr_if.wr_vld[0]), 32'd0);
        tick(); check("p0_hdr_vld", 32'(wr_if.wr_vld[0]), 32'd1);
                check("p0_hdr", 32'(wr_if.wr_data[0]), 32'({9'd1, 3'd0, 4'd0}));
        tick(); check("p0_pay", 32'(wr_if.wr_data[0]), 32'h0000);
                check("p0_pay_vld", 32'(wr_if.wr_vld[0]), 32'd1);
        tick(); check("p0_eop", 32'(wr_if.wr_eop[0]), 32'd1);
        tick(); check("p0_done", 32'(done[0]), 32'd1);
                check("p0_busy", 32'(busy[0]), 32'd0);

        // port 3: two packets, gap 2, 5-cycle pause mid-payload
        cfg_write(3, 3, 4, 31, 2, 2);
        check("p3_cfg_ok", 32'(cfg_err), 32'd0);
        push_pkt(3, 31, 4, 3, 0);
        push_pkt(3, 31, 4, 3, 1);
        start[3] = 1'b1; tick(); start = '0;
        repeat (13) tick();
        check("p3_k10", 32'(wr_if.wr_data[3]), 32'h000A);
        wr_if.pause[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p3_paused_vld", 32'(wr_if.wr_vld[3]), 32'd0);
        end
        wr_if.pause[3] = 1'b0;
        tick();
        check("p3_k11", 32'(wr_if.wr_data[3]), 32'h000B);
        wait_flag("p3_eop1", 3, 1, 100);
        idle = 0;
        tick();
        while (!wr_if.wr_sop[3] && idle < 10) begin idle++; tick(); end
        check("p3_gap", 32'(idle), 32'd2);
        check("p3_beats", 32'(pkt_beats[3]), 32'd32);
        wait_flag("p3_done", 3, 2, 100);
        check("p3_sb_empty", 32'(exp_q[3].size()), 32'd0);

        // port 5: unbounded, stop during packet 4
        cfg_write(5, 5, 1, 2, 0, 1);
        for (int s = 0; s < 4; s++) push_pkt(5, 2, 1, 5, s);
        start[5] = 1'b1; tick(); start = '0;
        n = 0;
        while (sop_cnt[5] < 4 && n < 200) begin tick(); n++; end
        stop[5] = 1'b1; tick(); stop = '0;
        wait_flag("p5_done", 5, 2, 100);
        repeat (10) tick();
        check("p5_sops", 32'(sop_cnt[5]), 32'd4);
        check("p5_eops", 32'(eop_cnt[5]), 32'd4);
        check("p5_sb_empty", 32'(exp_q[5].size()), 32'd0);

        // rejected config writes
        cfg_write(7, 7, 2, 8, 1, 0);
        check("p7_cfg_ok", 32'(cfg_err), 32'd0);
        push_pkt(7, 8, 2, 7, 0);
        start[7] = 1'b1; tick(); start = '0;
        cfg_write(7, 1, 1, 3, 1, 0);
        check("busy_cfg_err", 32'(cfg_err), 32'd1);
        tick();
        check("cfg_err_pulse", 32'(cfg_err), 32'd0);
        cfg_write(8, 1, 1, 0, 1, 0);
        check("len0_cfg_err", 32'(cfg_err), 32'd1);
        wait_flag("p7_done", 7, 2, 100);
        push_pkt(8, 1, 0, 8, 0);
        start[8] = 1'b1; tick(); start = '0;
        wait_flag("p8_done", 8, 2, 50);
        check("sb_empty_pre_rst", 32'(q_total()), 32'd0);

        // reset mid-payload
        cfg_write(9, 9, 0, 10, 1, 0);
        push_pkt(9, 10, 0, 9, 0);
        start[9] = 1'b1; tick(); start = '0;
        repeat (5) tick();
        rst = 1'b1; tick();
        check("mid_rst_sop", 32'(wr_if.wr_sop), 32'd0);
        check("mid_rst_vld", 32'(wr_if.wr_vld), 32'd0);
        check("mid_rst_eop", 32'(wr_if.wr_eop), 32'd0);
        check("mid_rst_data", 32'(wr_if.wr_data != '0), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        exp_q[9].delete();
        repeat (5) tick();
        check("p9_no_eop", 32'(eop_cnt[9]), 32'd0);

        // all ports in parallel with random back-pressure
        for (int p = 0; p < NP; p++) begin
            cfg_write(p, NP - 1 - p, p % 8, p + 2, 2, p % 3);
            check($sformatf("all_cfg_p%0d", p), 32'(cfg_err), 32'd0);
            push_pkt(p, p + 2, p % 8, NP - 1 - p, 0);
            push_pkt(p, p + 2, p % 8, NP - 1 - p, 1);
        end
        start = '1; tick(); start = '0;
        n = 0;
        while (!(done == '1 && busy == '0) && n < 1000) begin
            wr_if.pause = NP'($urandom);
            tick();
            n++;
        end
        wr_if.pause = '0;
        tick();
        check("all_done", 32'(done), 32'h0000_FFFF);
        check("all_sb_empty", 32'(q_total()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
